// File: rtl/regfile_alu_sequencer.sv
// Sequences register_file reads, ALU execution and write-back, and arbitrates the
// register-file write port with a host preload port. SEQ_INSTR_COUNT_EN adds instr_count.
module regfile_alu_sequencer #(
  parameter  int unsigned DATA_W = 12,
  parameter  int unsigned ADDR_W = 3,
  parameter  int unsigned OP_W   = 3,
  localparam int unsigned IW     = OP_W + 3 * ADDR_W,
  localparam int unsigned AW     = OP_W + 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_instr,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic [ADDR_W-1:0] read_addr1,
  output logic [ADDR_W-1:0] read_addr2,
  input  logic [DATA_W-1:0] read_out1,
  input  logic [DATA_W-1:0] read_out2,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              write_en,
  output logic [AW-1:0]     alu_ins,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
`ifdef SEQ_INSTR_COUNT_EN
  output logic [15:0]       instr_count,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HWRITE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_read_addr1;
  logic [ADDR_W-1:0] r_read_addr2;
  logic [AW-1:0]     r_alu_ins;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_data_in;
  logic              r_write_en;
  logic              r_done;
  logic              r_host_ack;
  logic              r_busy;

  logic [OP_W-1:0]   w_op_nxt;
  logic [ADDR_W-1:0] w_rd_nxt;
  logic [ADDR_W-1:0] w_read_addr1_nxt;
  logic [ADDR_W-1:0] w_read_addr2_nxt;
  logic [AW-1:0]     w_alu_ins_nxt;
  logic [ADDR_W-1:0] w_write_addr_nxt;
  logic [DATA_W-1:0] w_data_in_nxt;
  logic              w_write_en_nxt;
  logic              w_done_nxt;
  logic              w_host_ack_nxt;
  logic              w_busy_nxt;

  // Instruction fields: {op, rd, rs1, rs2}
  logic [OP_W-1:0]   w_in_op;
  logic [ADDR_W-1:0] w_in_rd;
  logic [ADDR_W-1:0] w_in_rs1;
  logic [ADDR_W-1:0] w_in_rs2;

  assign w_in_op  = in_instr[IW-1 -: OP_W];
  assign w_in_rd  = in_instr[3*ADDR_W-1 -: ADDR_W];
  assign w_in_rs1 = in_instr[2*ADDR_W-1 -: ADDR_W];
  assign w_in_rs2 = in_instr[ADDR_W-1:0];

  assign in_ready = (r_state == S_IDLE) & ~host_we & ~rst;

  // Next-state and next-output logic; datapath registers hold unless a state updates them.
  always_comb begin
    w_next_state     = r_state;
    w_op_nxt         = r_op;
    w_rd_nxt         = r_rd;
    w_read_addr1_nxt = r_read_addr1;
    w_read_addr2_nxt = r_read_addr2;
    w_alu_ins_nxt    = r_alu_ins;
    w_write_addr_nxt = r_write_addr;
    w_data_in_nxt    = r_data_in;
    w_write_en_nxt   = 1'b0;
    w_done_nxt       = 1'b0;
    w_host_ack_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (host_we) begin
          w_next_state     = S_HWRITE;
          w_write_addr_nxt = host_addr;
          w_data_in_nxt    = host_data;
          w_write_en_nxt   = 1'b1;
          w_host_ack_nxt   = 1'b1;
        end else if (in_valid && in_ready) begin
          w_next_state     = S_READ;
          w_op_nxt         = w_in_op;
          w_rd_nxt         = w_in_rd;
          w_read_addr1_nxt = w_in_rs1;
          w_read_addr2_nxt = w_in_rs2;
        end
      end
      S_HWRITE: w_next_state = S_IDLE;
      S_READ: begin
        w_next_state  = S_EXEC;
        w_alu_ins_nxt = {r_op, read_out1, read_out2};
      end
      S_EXEC: begin
        if (r_op != '0) begin
          w_next_state     = S_WRITE;
          w_write_addr_nxt = r_rd;
          w_data_in_nxt    = alu_out;
          w_write_en_nxt   = 1'b1;
        end else begin
          w_next_state = S_IDLE;
          w_done_nxt   = 1'b1;
        end
      end
      S_WRITE: begin
        w_next_state = S_IDLE;
        w_done_nxt   = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase

    w_busy_nxt = (w_next_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_rd         <= '0;
      r_read_addr1 <= '0;
      r_read_addr2 <= '0;
      r_alu_ins    <= '0;
      r_write_addr <= '0;
      r_data_in    <= '0;
      r_write_en   <= 1'b0;
      r_done       <= 1'b0;
      r_host_ack   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_op         <= w_op_nxt;
      r_rd         <= w_rd_nxt;
      r_read_addr1 <= w_read_addr1_nxt;
      r_read_addr2 <= w_read_addr2_nxt;
      r_alu_ins    <= w_alu_ins_nxt;
      r_write_addr <= w_write_addr_nxt;
      r_data_in    <= w_data_in_nxt;
      r_write_en   <= w_write_en_nxt;
      r_done       <= w_done_nxt;
      r_host_ack   <= w_host_ack_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign read_addr1 = r_read_addr1;
  assign read_addr2 = r_read_addr2;
  assign alu_ins    = r_alu_ins;
  assign write_addr = r_write_addr;
  assign data_in    = r_data_in;
  assign done       = r_done;
  assign host_ack   = r_host_ack;
  assign busy       = r_busy;
  // Reset also masks a write already on the port so an aborted write-back never lands.
  assign write_en   = r_write_en & ~rst;

`ifdef SEQ_INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= '0;
    end else if (w_done_nxt) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign instr_count = r_instr_count;
`endif

  a_we_single: assert property (@(posedge clk) disable iff (rst) r_write_en |=> !r_write_en);
  a_we_state:  assert property (@(posedge clk) disable iff (rst)
                 r_write_en |-> (r_state == S_HWRITE || r_state == S_WRITE));
  a_done_idle: assert property (@(posedge clk) disable iff (rst) r_done |-> (r_state == S_IDLE));

endmodule
